// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 3x4 keypad column scanner, debounce and MCU interrupt handshake.
// Ports: CLK, RST_N (async, active-low), ROW[3:0] in (async), COL[2:0] out (one-hot),
//        KEY_CODE[3:0], KEY_VALID, INTR, OVERRUN out, INTR_ACK in.
// Option: define KP_REPEAT_EN to re-raise INTR every REPEAT_DLY cycles while a key is held.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DLY   = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] ROW,
  output logic [2:0] COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       INTR,
  input  logic       INTR_ACK,
  output logic       OVERRUN
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_m_q, row_s_q;
  logic [2:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_lat_q, row_lat_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          intr_q, intr_d;
  logic          ovr_q, ovr_d;
  logic          accept;
  logic          irq_set;
  logic          row_one;
  logic [2:0]    col_nxt;

  function automatic logic [3:0] map_key(input logic [3:0] r,
                                         input logic [2:0] c);
    logic [3:0] ci;
    logic [3:0] k;
    ci = 4'd0;
    unique case (1'b1)
      c[1]:    ci = 4'd1;
      c[2]:    ci = 4'd2;
      default: ci = 4'd0;
    endcase
    k = 4'd0;
    unique case (1'b1)
      r[0]:    k = 4'd1 + ci;
      r[1]:    k = 4'd4 + ci;
      r[2]:    k = 4'd7 + ci;
      r[3]:    k = (ci == 4'd0) ? 4'hA :
                   (ci == 4'd1) ? 4'h0 : 4'hB;
      default: k = 4'd0;
    endcase
    return k;
  endfunction

  // zero or several rows high is not a usable single-key reading
  assign row_one = (row_s_q != 4'd0) &&
                   ((row_s_q & (row_s_q - 4'd1)) == 4'd0);
  assign col_nxt = {col_q[1:0], col_q[2]};

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    row_lat_d = row_lat_q;
    code_d    = code_q;
    valid_d   = valid_q;
    accept    = 1'b0;
    unique case (state_q)
      S_SCAN: begin
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          if (row_one) begin
            row_lat_d = row_s_q;
            cnt_d     = '0;
            state_d   = S_DEB;
          end else begin
            col_d = col_nxt;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      S_DEB: begin
        if (row_s_q == row_lat_q) begin
          if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
            cnt_d   = '0;
            accept  = 1'b1;
            code_d  = map_key(row_lat_q, col_q);
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          col_d   = col_nxt;
          state_d = S_SCAN;
        end
      end
      S_HOLD: begin
        if (row_s_q == 4'd0) begin
          if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
            cnt_d   = '0;
            valid_d = 1'b0;
            col_d   = col_nxt;
            state_d = S_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

`ifdef KP_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_fire;

  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == S_HOLD && row_s_q == row_lat_q) begin
      if (rep_q == RW'(REPEAT_DLY - 1)) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rep_q <= '0;
    else        rep_q <= rep_d;
  end

  assign irq_set = accept | rep_fire;
`else
  assign irq_set = accept;
`endif

  // a new interrupt beats a same-cycle ack; it only flags
  // overrun when the previous one is left unacknowledged
  always_comb begin
    intr_d = intr_q;
    ovr_d  = ovr_q;
    if (irq_set) begin
      intr_d = 1'b1;
      if (intr_q) ovr_d = ~INTR_ACK;
    end else if (intr_q && INTR_ACK) begin
      intr_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_m_q   <= 4'd0;
      row_s_q   <= 4'd0;
      state_q   <= S_SCAN;
      col_q     <= 3'b001;
      dwell_q   <= '0;
      cnt_q     <= '0;
      row_lat_q <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      row_m_q   <= ROW;
      row_s_q   <= row_m_q;
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      row_lat_q <= row_lat_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      intr_q    <= intr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign COL       = col_q;
  assign KEY_CODE  = code_q;
  assign KEY_VALID = valid_q;
  assign INTR      = intr_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad model + behavioural reference for keypad_scan_ctrl.
// Directed scenarios followed by randomized presses, checked every cycle.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_DLY   = 64;
`ifdef KP_REPEAT_EN
  localparam int EXP_REP = 4;
`else
  localparam int EXP_REP = 1;
`endif

  logic       CLK;
  logic       RST_N;
  logic [3:0] ROW;
  logic [2:0] COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       INTR;
  logic       INTR_ACK;
  logic       OVERRUN;

  keypad_scan_ctrl #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_DLY  (REPEAT_DLY)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ROW      (ROW),
    .COL      (COL),
    .KEY_CODE (KEY_CODE),
    .KEY_VALID(KEY_VALID),
    .INTR     (INTR),
    .INTR_ACK (INTR_ACK),
    .OVERRUN  (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int rises = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- keypad ----------------
  int         kp_mode = 0;
  logic [3:0] kp_row  = 4'd0;
  logic [2:0] kp_col  = 3'd0;
  logic [3:0] kp_raw  = 4'd0;

  initial begin
    ROW = 4'd0;
    forever begin
      @(negedge CLK);
      case (kp_mode)
        1:       ROW = ((COL & kp_col) != 3'd0) ? kp_row : 4'd0;
        2:       ROW = kp_raw;
        default: ROW = 4'd0;
      endcase
    end
  end

  task automatic press(input int r, input int c);
    kp_row  = 4'(1 << r);
    kp_col  = 3'(1 << c);
    kp_mode = 1;
  endtask

  // ---------------- reference model ----------------
  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD    = 2;

  int kmap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

  logic [3:0] m_s1, m_s2, m_row;
  int m_mode, m_ci, m_dwell, m_press_run, m_rel_run, m_rep, m_code;
  bit m_valid, m_intr, m_ovr;

  task automatic model_reset();
    m_s1 = 4'd0; m_s2 = 4'd0; m_row = 4'd0;
    m_mode = M_SCAN; m_ci = 0; m_dwell = 0;
    m_press_run = 0; m_rel_run = 0; m_rep = 0; m_code = 0;
    m_valid = 0; m_intr = 0; m_ovr = 0;
  endtask

  function automatic int row_index(input logic [3:0] r);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (r[i]) idx = i;
    return idx;
  endfunction

  task automatic model_step(input logic [3:0] row_in, input bit ack);
    logic [3:0] rs;
    bit acc;
    rs = m_s2;
    m_s2 = m_s1;
    m_s1 = row_in;
    acc = 0;
    if (m_mode == M_SCAN) begin
      if (m_dwell == SCAN_DIV - 1) begin
        m_dwell = 0;
        if ($countones(rs) == 1) begin
          m_row = rs; m_mode = M_CONFIRM; m_press_run = 0;
        end else begin
          m_ci = (m_ci + 1) % 3;
        end
      end else begin
        m_dwell++;
      end
    end else if (m_mode == M_CONFIRM) begin
      if (rs == m_row) begin
        m_press_run++;
        if (m_press_run == DEBOUNCE_CNT) begin
          acc = 1; m_mode = M_HELD; m_valid = 1;
          m_code = kmap[row_index(m_row)][m_ci];
          m_rel_run = 0; m_rep = 0;
        end
      end else begin
        m_mode = M_SCAN; m_ci = (m_ci + 1) % 3; m_dwell = 0;
      end
    end else begin
      if (rs == 4'd0) begin
        m_rel_run++;
        if (m_rel_run == DEBOUNCE_CNT) begin
          m_valid = 0; m_mode = M_SCAN; m_ci = (m_ci + 1) % 3; m_dwell = 0;
        end
      end else begin
        m_rel_run = 0;
      end
`ifdef KP_REPEAT_EN
      if (rs == m_row) begin
        m_rep++;
        if (m_rep == REPEAT_DLY) begin acc = 1; m_rep = 0; end
      end else begin
        m_rep = 0;
      end
`endif
    end
    if (acc) begin
      if (m_intr) m_ovr = !ack;
      m_intr = 1;
    end else if (m_intr && ack) begin
      m_intr = 0; m_ovr = 0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    bit intr_prev;
    intr_prev = 0;
    model_reset();
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) model_reset();
      else model_step(ROW, INTR_ACK === 1'b1);
      #1;
      check("col", int'(COL), 1 << m_ci);
      check("key_code", int'(KEY_CODE), m_code);
      check("key_valid", int'(KEY_VALID), int'(m_valid));
      check("intr", int'(INTR), int'(m_intr));
      check("overrun", int'(OVERRUN), int'(m_ovr));
      if (INTR === 1'b1 && !intr_prev) rises++;
      intr_prev = (INTR === 1'b1);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_intr(input string name, input int bound, output int lat);
    int t0;
    bit done;
    t0 = -1; lat = -1; done = 0;
    for (int i = 1; i <= bound && !done; i++) begin
      @(posedge CLK); #1;
      if (t0 < 0 && ROW != 4'd0) t0 = i;
      if (INTR === 1'b1) begin
        done = 1;
        lat = (t0 < 0) ? 0 : i - t0;
      end
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string name, input bit lvl,
                            input int bound, output int el);
    bit done;
    done = 0; el = -1;
    for (int i = 1; i <= bound && !done; i++) begin
      @(posedge CLK); #1;
      if (KEY_VALID === lvl) begin done = 1; el = i; end
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic ack_once();
    @(negedge CLK); INTR_ACK = 1'b1;
    @(negedge CLK); INTR_ACK = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, el, base;
    bit found;
    RST_N = 1'b0;
    INTR_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_col", int'(COL), 1);
    check("rst_code", int'(KEY_CODE), 0);
    check("rst_valid", int'(KEY_VALID), 0);
    check("rst_intr", int'(INTR), 0);
    check("rst_ovr", int'(OVERRUN), 0);
    RST_N = 1'b1;
    repeat (4) @(posedge CLK); #1;
    check("rot_010", int'(COL), 2);
    repeat (4) @(posedge CLK); #1;
    check("rot_100", int'(COL), 4);

    // key 5
    @(negedge CLK);
    press(1, 1);
    wait_intr("k5", 40, lat);
    check("k5_latency_ok", int'(lat >= 0 && lat <= 14), 1);
    check("k5_code", int'(KEY_CODE), 5);
    check("k5_valid", int'(KEY_VALID), 1);
    repeat (3) @(negedge CLK);
    check("k5_pending", int'(INTR), 1);
    INTR_ACK = 1'b1;
    @(posedge CLK); #1;
    check("k5_acked", int'(INTR), 0);
    @(negedge CLK); INTR_ACK = 1'b0;
    repeat (30) @(negedge CLK);
    kp_mode = 0;
    wait_valid("k5_rel", 1'b0, 20, el);
    check("k5_rel_time_ok", int'(el > 0 && el <= 12), 1);
    check("k5_rel_col", int'(COL), 4);

    // bounce
    repeat (10) @(negedge CLK);
    base = rises;
    for (int k = 0; k < 5; k++) begin
      press(1, 1);
      repeat (3) @(negedge CLK);
      kp_mode = 0;
      repeat (3) @(negedge CLK);
    end
    check("bounce_quiet", rises - base, 0);
    press(1, 1);
    wait_intr("bounce", 40, lat);
    check("bounce_code", int'(KEY_CODE), 5);
    repeat (20) @(negedge CLK);
    check("bounce_one_intr", rises - base, 1);
    ack_once();
    kp_mode = 0;
    wait_valid("bounce_rel", 1'b0, 20, el);

    // overrun then simultaneous accept/ack
    @(negedge CLK);
    press(3, 2);
    wait_intr("hash", 40, lat);
    check("hash_code", int'(KEY_CODE), 11);
    @(negedge CLK); kp_mode = 0;
    wait_valid("hash_rel", 1'b0, 20, el);
    @(negedge CLK); press(0, 0);
    wait_valid("one_press", 1'b1, 40, el);
    check("ovr_code", int'(KEY_CODE), 1);
    check("ovr_intr", int'(INTR), 1);
    check("ovr_flag", int'(OVERRUN), 1);
    @(negedge CLK); kp_mode = 0;
    wait_valid("one_rel", 1'b0, 20, el);
    @(negedge CLK); press(3, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      if (m_mode == M_CONFIRM && m_press_run == DEBOUNCE_CNT - 1 &&
          m_s2 == m_row) begin
        INTR_ACK = 1'b1;
        found = 1;
      end
    end
    check("simul_reached", int'(found), 1);
    @(negedge CLK); INTR_ACK = 1'b0;
    check("simul_intr", int'(INTR), 1);
    check("simul_code", int'(KEY_CODE), 10);
    check("simul_ovr", int'(OVERRUN), 0);
    ack_once();
    check("final_ack_intr", int'(INTR), 0);
    check("final_ack_ovr", int'(OVERRUN), 0);
    kp_mode = 0;
    wait_valid("star_rel", 1'b0, 20, el);

    // two rows high
    @(negedge CLK);
    base = rises;
    kp_raw = 4'b0101;
    kp_mode = 2;
    repeat (50) @(negedge CLK);
    check("multi_no_intr", rises - base, 0);
    check("multi_valid", int'(KEY_VALID), 0);
    kp_mode = 0;
    repeat (5) @(negedge CLK);

    // reset mid-HOLD
    press(1, 1);
    wait_intr("pre_rst", 40, lat);
    repeat (2) @(negedge CLK);
    check("pre_rst_valid", int'(KEY_VALID), 1);
    RST_N = 1'b0;
    #1;
    check("arst_col", int'(COL), 1);
    check("arst_intr", int'(INTR), 0);
    check("arst_valid", int'(KEY_VALID), 0);
    check("arst_ovr", int'(OVERRUN), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(posedge CLK); #1;
    check("post_rst_rot", int'(COL), 2);
    wait_intr("redetect", 40, lat);
    check("redetect_code", int'(KEY_CODE), 5);
    ack_once();
    kp_mode = 0;
    wait_valid("redetect_rel", 1'b0, 20, el);

    // held key '9' with immediate acks
    @(negedge CLK);
    base = rises;
    press(2, 2);
    wait_intr("nine", 40, lat);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); INTR_ACK = INTR;
    end
    kp_mode = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK); INTR_ACK = INTR;
    end
    INTR_ACK = 1'b0;
    check("nine_intr_count", rises - base, EXP_REP);
    check("nine_code", int'(KEY_CODE), 9);

    // randomized presses
    for (int e = 0; e < 30; e++) begin
      int kind, len, gap;
      kind = $urandom_range(0, 2);
      len = $urandom_range(5, 60);
      gap = $urandom_range(12, 30);
      if (kind == 2) begin
        kp_raw = 4'($urandom_range(0, 15));
        kp_mode = 2;
      end else begin
        press($urandom_range(0, 3), $urandom_range(0, 2));
      end
      for (int i = 0; i < len; i++) begin
        @(negedge CLK);
        INTR_ACK = ($urandom_range(0, 3) == 0);
        if (kind == 1 && i < 12) kp_mode = ((i / 2) % 2 == 0) ? 1 : 0;
      end
      kp_mode = 0;
      for (int i = 0; i < gap; i++) begin
        @(negedge CLK);
        INTR_ACK = ($urandom_range(0, 3) == 0);
      end
    end
    INTR_ACK = 1'b0;
    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scan sequencer and CPU interrupt handshake for the 3-column x 4-row membrane keypad.
- Drives one column at a time and samples the asynchronous row lines through a synchronizer.
- Debounces a single-key press, latches a 4-bit key code and raises an interrupt to the MCU that is held until acknowledged.
- Sits between the keypad pins and the MCU input port / interrupt line.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven (dwell), >= 2.
- DEBOUNCE_CNT, 8: consecutive stable cycles required for press and for release.
- REPEAT_DLY, 64: cycles a held key must stay pressed before it re-interrupts (only with KP_REPEAT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ROW  in  4  keypad row lines, active-high, asynchronous.
- COL  out  3  one-hot column drive, active-high.
- KEY_CODE  out  4  last accepted key code.
- KEY_VALID  out  1  high while accepted key is still held.
- INTR  out  1  interrupt request to MCU, level, held until acknowledged.
- INTR_ACK  in  1  MCU acknowledge, sampled on rising CLK.
- OVERRUN  out  1  sticky: a new key replaced an unacknowledged one.

Behaviour:
- Single clock CLK; reset is asynchronous and active-low (RST_N).
- Reset values: COL=3'b001, KEY_CODE=0, KEY_VALID=0, INTR=0, OVERRUN=0, state=SCAN, all counters=0.
- ROW passes through a 2-FF synchronizer (rowS). All decisions use rowS.
- Key map (row r, col c): r0:1,2,3; r1:4,5,6; r2:7,8,9; r3: *=4'hA, 0=4'h0, #=4'hB.
- SCAN state:
  - COL is held for SCAN_DIV cycles.
  - On the last dwell cycle, if rowS is one-hot: latch col/row, freeze COL, go to DEBOUNCE.
  - Otherwise advance COL 001->010->100->001.
  - rowS=0 or multiple bits set is treated as no key (ignored).
- DEBOUNCE state:
  - Count cycles where rowS equals the latched row.
  - Any mismatch: return to SCAN, counter cleared, COL advances.
  - On DEBOUNCE_CNT matches in a row: on the next edge KEY_CODE=mapped code, KEY_VALID=1, INTR=1, go to HOLD.
- HOLD state:
  - COL stays frozen.
  - Release requires rowS==0 for DEBOUNCE_CNT consecutive cycles; any nonzero sample restarts the count.
  - On release: KEY_VALID=0, go to SCAN with COL advanced.
  - KEY_CODE keeps its value after release.
- INTR handshake, independent of state:
  - INTR=1 and INTR_ACK=1 at an edge: INTR=0 and OVERRUN=0 on that edge.
  - Release before ack does not clear INTR.
  - Key accepted while INTR=1 and no ack that cycle: KEY_CODE overwritten, INTR stays 1, OVERRUN=1.
  - Key accept and ack in the same cycle: accept wins. INTR=1, KEY_CODE=new, OVERRUN=0.
  - INTR_ACK while INTR=0: no effect.
- Latency, press to INTR: 2 (sync) + remaining dwell (0..SCAN_DIV-1) + DEBOUNCE_CNT + 1 cycles.
- Reset mid-operation (any state): immediate return to the reset values above. A key still held after reset is re-detected as a fresh press.

Optional Feature:
- Macro: KP_REPEAT_EN.
- Defined:
  - In HOLD, a counter runs while the key stays pressed. It clears whenever rowS deviates from the latched row.
  - When it reaches REPEAT_DLY: INTR=1 again with the same KEY_CODE (same OVERRUN rule), and the counter restarts.
  - Repeats continue every REPEAT_DLY cycles until release.
- Not defined: the repeat counter is absent. Exactly one INTR per press.

Test Plan:
- Reset: RST_N=0 mid-HOLD with INTR=1 -> asynchronously COL=001, INTR=0, KEY_VALID=0, OVERRUN=0. After release of reset, COL rotates every 4 cycles.
- Key 5 (ROW=4'b0010 while COL=010), held 40 cycles then released, ack 3 cycles after INTR:
  - INTR rises within 2+3+8+1 cycles of the press; KEY_CODE=4'h5, KEY_VALID=1.
  - INTR falls the edge after ack.
  - KEY_VALID falls 8 cycles after release; COL advances to 100.
- Bounce: ROW toggles 0010/0000 every 3 cycles for 30 cycles, then stable -> no INTR during bouncing. Exactly one INTR after 8 stable cycles, code 4'h5.
- Overrun: press '#' (row3,col100), no ack, release, then press '1' (row0,col001) -> KEY_CODE=4'h1, INTR=1, OVERRUN=1. Ack -> INTR=0, OVERRUN=0.
- Simultaneous: INTR_ACK asserted on the exact cycle '*' is accepted while an older INTR is pending -> INTR=1, KEY_CODE=4'hA, OVERRUN=0.
- Two rows high (ROW=4'b0101) held 50 cycles -> no DEBOUNCE entry, INTR=0, COL keeps rotating. With KP_REPEAT_EN, holding '9' for 200 cycles with immediate acks -> 4 INTR assertions (initial plus 3 repeats at 64-cycle spacing).
